// File: rtl/tcb_pkg.sv
//------------------------------------------------------------------------------
// Module      : tcb_pkg
// Description : Shared TCB bus defaults (widths, response delay) and helpers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tcb_pkg;

    localparam int TCB_ABW = 32;
    localparam int TCB_DBW = 32;
    localparam int TCB_SLW = 8;
    localparam int TCB_DLY = 1;

    // Number of byte-select granules in a data word.
    function automatic int tcb_bew(input int dbw, input int slw);
        return dbw / slw;
    endfunction

endpackage : tcb_pkg

`default_nettype wire

// File: rtl/tcb_rsp_pipe.sv
//------------------------------------------------------------------------------
// Module      : tcb_rsp_pipe
// Description : DLY-deep read-data/error pipeline; stage 0 loads zero when idle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tcb_rsp_pipe
    import tcb_pkg::*;
#(
    parameter int DBW = TCB_DBW,
    parameter int DLY = TCB_DLY
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           trn,
    input  logic [DBW-1:0] sub_rdt,
    input  logic           sub_err,
    output logic [DBW-1:0] rdt,
    output logic           err
);

    logic [DBW-1:0] rdt_q [DLY];
    logic           err_q [DLY];
    logic [DBW-1:0] rdt_d;
    logic           err_d;

    // Zero-filling idle slots keeps stale data off the bus between responses.
    assign rdt_d = trn ? sub_rdt : '0;
    assign err_d = trn & sub_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) begin
                rdt_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            rdt_q[0] <= rdt_d;
            err_q[0] <= err_d;
            for (int i = 1; i < DLY; i++) begin
                rdt_q[i] <= rdt_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    assign rdt = rdt_q[DLY-1];
    assign err = err_q[DLY-1];

endmodule : tcb_rsp_pipe

`default_nettype wire

// File: rtl/tcb_if_core.sv
//------------------------------------------------------------------------------
// Module      : tcb_if_core
// Description : TCB handshake decode plus a DLY-cycle response path.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tcb_if_core
    import tcb_pkg::*;
#(
    parameter int ABW = TCB_ABW,
    parameter int DBW = TCB_DBW,
    parameter int SLW = TCB_SLW,
    parameter int BEW = tcb_bew(DBW, SLW),
    parameter int DLY = TCB_DLY
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vld,
    input  logic           rdy,
    input  logic [DBW-1:0] sub_rdt,
    input  logic           sub_err,
    output logic           trn,
    output logic           idl,
    output logic           rsp,
    output logic [DBW-1:0] rdt,
    output logic           err
);

    if ((SLW <= 0) || ((DBW % SLW) != 0) || (BEW != DBW / SLW) || (ABW <= 0) || (DLY < 0)) begin : g_param_chk
        $error("tcb_if_core: illegal parameters ABW=%0d DBW=%0d SLW=%0d BEW=%0d DLY=%0d",
               ABW, DBW, SLW, BEW, DLY);
    end

    assign trn = vld & rdy;
    assign idl = ~vld | trn;

    if (DLY == 0) begin : g_dly0
        assign rsp = trn;
        assign rdt = trn ? sub_rdt : '0;
        assign err = trn & sub_err;
    end else begin : g_dly_pipe
        logic [DBW-1:0] pipe_rdt;
        logic           pipe_err;

        tcb_rsp_pipe #(
            .DBW (DBW),
            .DLY (DLY)
        ) u_rsp_pipe (
            .clk     (clk),
            .rst_n   (rst_n),
            .trn     (trn),
            .sub_rdt (sub_rdt),
            .sub_err (sub_err),
            .rdt     (pipe_rdt),
            .err     (pipe_err)
        );

        if (DLY == 1) begin : g_dly1
            logic rsp_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rsp_q <= 1'b0;
                end else begin
                    rsp_q <= trn;
                end
            end

            assign rsp = rsp_q;
        end else begin : g_dlyn
            logic [DLY-1:0] que_q;
            logic [DLY-1:0] que_d;

            assign que_d = {que_q[DLY-2:0], trn};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    que_q <= '0;
                end else begin
                    que_q <= que_d;
                end
            end

            assign rsp = que_q[DLY-1];
        end

        // The pipeline already zero-fills, but gating keeps the bus quiet by construction.
        assign rdt = rsp ? pipe_rdt : '0;
        assign err = rsp & pipe_err;
    end

endmodule : tcb_if_core

`default_nettype wire

// File: tb/tb_tcb_if_core.sv
//------------------------------------------------------------------------------
// Module      : tb_tcb_if_core
// Description : Directed self-checking bench for tcb_if_core at DLY 0/1/2/4.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tcb_if_core;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic        rdy;
    logic [31:0] sub_rdt;
    logic        sub_err;

    logic        trn0, idl0, rsp0, err0;
    logic        trn1, idl1, rsp1, err1;
    logic        trn2, idl2, rsp2, err2;
    logic        trn4, idl4, rsp4, err4;
    logic [31:0] rdt0, rdt1, rdt2, rdt4;

    int errors = 0;
    int checks = 0;

    tcb_if_core #(.DLY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .vld(vld), .rdy(rdy), .sub_rdt(sub_rdt), .sub_err(sub_err),
        .trn(trn0), .idl(idl0), .rsp(rsp0), .rdt(rdt0), .err(err0));
    tcb_if_core #(.DLY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .vld(vld), .rdy(rdy), .sub_rdt(sub_rdt), .sub_err(sub_err),
        .trn(trn1), .idl(idl1), .rsp(rsp1), .rdt(rdt1), .err(err1));
    tcb_if_core #(.DLY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .vld(vld), .rdy(rdy), .sub_rdt(sub_rdt), .sub_err(sub_err),
        .trn(trn2), .idl(idl2), .rsp(rsp2), .rdt(rdt2), .err(err2));
    tcb_if_core #(.DLY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .vld(vld), .rdy(rdy), .sub_rdt(sub_rdt), .sub_err(sub_err),
        .trn(trn4), .idl(idl4), .rsp(rsp4), .rdt(rdt4), .err(err4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then settle before checking.
    task automatic cyc(input logic v, input logic r, input logic [31:0] d, input logic e);
        @(posedge clk);
        #1;
        vld     = v;
        rdy     = r;
        sub_rdt = d;
        sub_err = e;
        #3;
    endtask

    task automatic chk_rsp(input string tag, input logic rs, input logic [31:0] rd,
                           input logic er, input logic exp_rs, input logic [31:0] exp_rd,
                           input logic exp_er);
        chk({tag, ".rsp"}, {31'd0, rs}, {31'd0, exp_rs});
        chk({tag, ".rdt"}, rd, exp_rd);
        chk({tag, ".err"}, {31'd0, er}, {31'd0, exp_er});
    endtask

    logic [31:0] b2b_d [3];
    logic        b2b_e [3];

    initial begin
        rst_n = 1'b0; vld = 1'b0; rdy = 1'b0; sub_rdt = '0; sub_err = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk_rsp("rst.d2", rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        chk_rsp("rst.d1", rsp1, rdt1, err1, 1'b0, 32'h0, 1'b0);
        chk_rsp("rst.d4", rsp4, rdt4, err4, 1'b0, 32'h0, 1'b0);
        vld = 1'b1; rdy = 1'b1; sub_rdt = 32'hDEAD_BEEF;
        #1;
        chk("rst.trn", {31'd0, trn2}, 32'd1);
        chk("rst.idl", {31'd0, idl2}, 32'd1);
        chk("rst.rsp0", {31'd0, rsp0}, 32'd1);
        chk_rsp("rst.hold.d2", rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        vld = 1'b0; rdy = 1'b0; sub_rdt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        chk_rsp("rst.post.d1", rsp1, rdt1, err1, 1'b0, 32'h0, 1'b0);

        // Single read with delay sweep
        cyc(1'b1, 1'b1, 32'h7654_3210, 1'b0);
        chk("rd.trn", {31'd0, trn2}, 32'd1);
        chk_rsp("rd.c0.d0", rsp0, rdt0, err0, 1'b1, 32'h7654_3210, 1'b0);
        chk_rsp("rd.c0.d1", rsp1, rdt1, err1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("rd.c1.d0", rsp0, rdt0, err0, 1'b0, 32'h0, 1'b0);
        chk_rsp("rd.c1.d1", rsp1, rdt1, err1, 1'b1, 32'h7654_3210, 1'b0);
        chk_rsp("rd.c1.d2", rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("rd.c2.d1", rsp1, rdt1, err1, 1'b0, 32'h0, 1'b0);
        chk_rsp("rd.c2.d2", rsp2, rdt2, err2, 1'b1, 32'h7654_3210, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("rd.c3.d2", rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        chk_rsp("rd.c3.d4", rsp4, rdt4, err4, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("rd.c4.d4", rsp4, rdt4, err4, 1'b1, 32'h7654_3210, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("rd.c5.d4", rsp4, rdt4, err4, 1'b0, 32'h0, 1'b0);

        // Ready without valid
        cyc(1'b0, 1'b1, 32'h1111_1111, 1'b1);
        chk("rdyonly.trn", {31'd0, trn2}, 32'd0);
        chk("rdyonly.idl", {31'd0, idl2}, 32'd1);
        chk("rdyonly.rsp0", {31'd0, rsp0}, 32'd0);

        // Backpressure: three stalled cycles then one accepted transfer
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'hBAD0_0000 + i, 1'b1);
            chk($sformatf("bp.stall%0d.trn", i), {31'd0, trn2}, 32'd0);
            chk($sformatf("bp.stall%0d.idl", i), {31'd0, idl2}, 32'd0);
            chk_rsp($sformatf("bp.stall%0d.d2", i), rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        end
        cyc(1'b1, 1'b1, 32'h0000_00AA, 1'b1);
        chk("bp.go.trn", {31'd0, trn2}, 32'd1);
        chk("bp.go.idl", {31'd0, idl2}, 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("bp.c1.d2", rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("bp.c2.d2", rsp2, rdt2, err2, 1'b1, 32'h0000_00AA, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("bp.c3.d2", rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // Back-to-back transfers
        b2b_d[0] = 32'd1; b2b_d[1] = 32'd2; b2b_d[2] = 32'd3;
        b2b_e[0] = 1'b0;  b2b_e[1] = 1'b1;  b2b_e[2] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 3) cyc(1'b1, 1'b1, b2b_d[i], b2b_e[i]);
            else       cyc(1'b0, 1'b0, 32'h0, 1'b0);
            if (i >= 2 && i <= 4)
                chk_rsp($sformatf("b2b.c%0d.d2", i), rsp2, rdt2, err2, 1'b1, b2b_d[i-2], b2b_e[i-2]);
            else
                chk_rsp($sformatf("b2b.c%0d.d2", i), rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
            if (i >= 4)
                chk_rsp($sformatf("b2b.c%0d.d4", i), rsp4, rdt4, err4, 1'b1, b2b_d[i-4], b2b_e[i-4]);
        end

        // Mid-flight reset discards the in-flight response
        repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0000_0055, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("mid.pre.d1", rsp1, rdt1, err1, 1'b1, 32'h0000_0055, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_rsp("mid.async.d1", rsp1, rdt1, err1, 1'b0, 32'h0, 1'b0);
        chk_rsp("mid.async.d2", rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        chk_rsp("mid.c2.d2", rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            chk_rsp($sformatf("mid.c%0d.d2", i + 3), rsp2, rdt2, err2, 1'b0, 32'h0, 1'b0);
            chk_rsp($sformatf("mid.c%0d.d4", i + 3), rsp4, rdt4, err4, 1'b0, 32'h0, 1'b0);
        end

        // Normal operation resumes after reset
        cyc(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("post.c1.d1", rsp1, rdt1, err1, 1'b1, 32'hCAFE_F00D, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        chk_rsp("post.c2.d2", rsp2, rdt2, err2, 1'b1, 32'hCAFE_F00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tcb_if_core

`default_nettype wire
